// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: chooses between sequential, jump and branch targets and raises flushes.
// Optional performance counters are built when PC_PERF_CNT_EN is defined; otherwise the outputs read zero.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        imem_ready_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        fetch_valid_o,
   output logic        flush_if_id_o,
   output logic        flush_id_ex_o,
   output logic        misalign_o,
   output logic [31:0] branch_cnt_o,
   output logic [31:0] jump_cnt_o,
   output logic [31:0] stall_cnt_o
);

   localparam logic [1:0] ST_BOOT     = 2'd0;
   localparam logic [1:0] ST_RUN      = 2'd1;
   localparam logic [1:0] ST_REDIRECT = 2'd2;

   localparam logic [31:0] STEP = 32'(PC_STEP);

   logic [1:0]  state_p0;
   logic [1:0]  state_nxt;
   logic [31:0] pc_p0;
   logic [31:0] pc_nxt;

   logic        active;
   logic        sel_branch;
   logic        sel_jump;
   logic        sel_hold;
   logic [31:0] target_raw;

   assign active = (state_p0 == ST_RUN) || (state_p0 == ST_REDIRECT);

   // Branch (EX, older) outranks jump (ID); both outrank stall and imem back-pressure.
   assign sel_branch = active && branch_taken_i;
   assign sel_jump   = active && !branch_taken_i && jump_i;
   assign sel_hold   = active && !branch_taken_i && !jump_i && (stall_i || !imem_ready_i);

   assign target_raw = sel_branch ? branch_target_i : jump_target_i;

   always_comb begin
      state_nxt = state_p0;
      pc_nxt    = pc_p0;
      case (state_p0)
         ST_BOOT: begin
            state_nxt = ST_RUN;
         end
         ST_RUN, ST_REDIRECT: begin
            if (sel_branch || sel_jump) begin
               pc_nxt    = {target_raw[31:2], 2'b00};
               state_nxt = ST_REDIRECT;
            end else if (sel_hold) begin
               state_nxt = ST_RUN;
            end else begin
               pc_nxt    = pc_p0 + STEP;
               state_nxt = ST_RUN;
            end
         end
         default: begin
            state_nxt = ST_BOOT;
            pc_nxt    = RESET_PC;
         end
      endcase
   end

   // Registered PC and control state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p0 <= ST_BOOT;
         pc_p0    <= RESET_PC;
      end else begin
         state_p0 <= state_nxt;
         pc_p0    <= pc_nxt;
      end
   end

   assign pc_o          = pc_p0;
   assign pc_plus4_o    = pc_p0 + STEP;
   assign fetch_valid_o = active;
   assign flush_if_id_o = sel_branch || sel_jump;
   assign flush_id_ex_o = sel_branch;
   assign misalign_o    = (sel_branch || sel_jump) && (target_raw[1:0] != 2'b00);

`ifdef PC_PERF_CNT_EN
   logic [31:0] branch_cnt_p0;
   logic [31:0] jump_cnt_p0;
   logic [31:0] stall_cnt_p0;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Stall cycles are counted in any fetch-active state where the PC was held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt_p0 <= '0;
         jump_cnt_p0   <= '0;
         stall_cnt_p0  <= '0;
      end else begin
         if (sel_branch) branch_cnt_p0 <= sat_inc(branch_cnt_p0);
         if (sel_jump)   jump_cnt_p0   <= sat_inc(jump_cnt_p0);
         if (sel_hold)   stall_cnt_p0  <= sat_inc(stall_cnt_p0);
      end
   end

   assign branch_cnt_o = branch_cnt_p0;
   assign jump_cnt_o   = jump_cnt_p0;
   assign stall_cnt_o  = stall_cnt_p0;
`else
   assign branch_cnt_o = 32'h0;
   assign jump_cnt_o   = 32'h0;
   assign stall_cnt_o  = 32'h0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer with RESET_PC = 0x100, plus an async-reset-mid-redirect sequence.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i, imem_ready_i, jump_i, branch_taken_i;
   logic [31:0] jump_target_i, branch_target_i;
   logic [31:0] pc_o, pc_plus4_o;
   logic        fetch_valid_o, flush_if_id_o, flush_id_ex_o, misalign_o;
   logic [31:0] branch_cnt_o, jump_cnt_o, stall_cnt_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_PC(32'h0000_0100), .PC_STEP(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .stall_i(stall_i), .imem_ready_i(imem_ready_i),
      .jump_i(jump_i), .jump_target_i(jump_target_i),
      .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
      .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .fetch_valid_o(fetch_valid_o),
      .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o), .misalign_o(misalign_o),
      .branch_cnt_o(branch_cnt_o), .jump_cnt_o(jump_cnt_o), .stall_cnt_o(stall_cnt_o)
   );

   typedef struct {
      logic        stall, ready, jump;
      logic [31:0] jt;
      logic        br;
      logic [31:0] bt;
      logic [31:0] pc;
      logic        fv, fif, fie, mis;
   } vec_t;

   localparam int NV = 27;
   vec_t v [NV];

   function automatic vec_t mk(logic stall, logic ready, logic jump, logic [31:0] jt,
                               logic br, logic [31:0] bt, logic [31:0] pc,
                               logic fv, logic fif, logic fie, logic mis);
      vec_t r;
      r.stall = stall; r.ready = ready; r.jump = jump; r.jt = jt; r.br = br; r.bt = bt;
      r.pc = pc; r.fv = fv; r.fif = fif; r.fie = fie; r.mis = mis;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic stall, input logic ready, input logic jump, input logic [31:0] jt,
                        input logic br, input logic [31:0] bt);
      stall_i = stall; imem_ready_i = ready; jump_i = jump; jump_target_i = jt;
      branch_taken_i = br; branch_target_i = bt;
   endtask

   task automatic chk_out(input string tag, input logic [31:0] pc, input logic fv,
                          input logic fif, input logic fie, input logic mis);
      chk({tag, " pc"}, pc_o, pc);
      chk({tag, " pc_plus4"}, pc_plus4_o, pc + 32'd4);
      chk({tag, " fetch_valid"}, {31'b0, fetch_valid_o}, {31'b0, fv});
      chk({tag, " flush_if_id"}, {31'b0, flush_if_id_o}, {31'b0, fif});
      chk({tag, " flush_id_ex"}, {31'b0, flush_id_ex_o}, {31'b0, fie});
      chk({tag, " misalign"}, {31'b0, misalign_o}, {31'b0, mis});
   endtask

   initial begin
      //          stall rdy jmp jt            br bt            pc            fv fif fie mis
      v[0]  = mk(0, 1, 1, 32'h0000_0500, 0, 32'h0,         32'h0000_0100, 0, 0, 0, 0); // BOOT ignores jump
      v[1]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0100, 1, 0, 0, 0);
      v[2]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0104, 1, 0, 0, 0);
      v[3]  = mk(0, 1, 1, 32'h0000_0200, 0, 32'h0,         32'h0000_0108, 1, 1, 0, 0);
      v[4]  = mk(0, 1, 0, 32'h0,         1, 32'h0000_0040, 32'h0000_0200, 1, 1, 1, 0);
      v[5]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0040, 1, 0, 0, 0);
      v[6]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0044, 1, 0, 0, 0);
      v[7]  = mk(1, 1, 1, 32'h0000_0800, 1, 32'h0000_0080, 32'h0000_0048, 1, 1, 1, 0);
      v[8]  = mk(0, 1, 1, 32'h0000_000C, 0, 32'h0,         32'h0000_0080, 1, 1, 0, 0);
      v[9]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h0000_000C, 1, 0, 0, 0);
      v[10] = mk(1, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0010, 1, 0, 0, 0);
      v[11] = mk(1, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0010, 1, 0, 0, 0);
      v[12] = mk(1, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0010, 1, 0, 0, 0);
      v[13] = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0010, 1, 0, 0, 0);
      v[14] = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0014, 1, 0, 0, 0);
      v[15] = mk(0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0018, 1, 0, 0, 0);
      v[16] = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0018, 1, 0, 0, 0);
      v[17] = mk(0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0000_001C, 1, 1, 0, 0);
      v[18] = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'hFFFF_FFFC, 1, 0, 0, 0);
      v[19] = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 1, 0, 0, 0);
      v[20] = mk(0, 1, 1, 32'h0000_0103, 0, 32'h0,         32'h0000_0004, 1, 1, 0, 1);
      v[21] = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0100, 1, 0, 0, 0);
      v[22] = mk(1, 0, 0, 32'h0,         1, 32'h0000_0041, 32'h0000_0104, 1, 1, 1, 1);
      v[23] = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0040, 1, 0, 0, 0);
      v[24] = mk(0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0044, 1, 0, 0, 0);
      v[25] = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0044, 1, 0, 0, 0);
      v[26] = mk(0, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0048, 1, 0, 0, 0);

      rst_n = 1'b0;
      drive(0, 1, 0, 32'h0, 0, 32'h0);
      repeat (2) @(negedge clk);
      #1 chk_out("reset", 32'h0000_0100, 0, 0, 0, 0);
      chk("reset branch_cnt", branch_cnt_o, 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NV; i++) begin
         if (i != 0) @(negedge clk);
         drive(v[i].stall, v[i].ready, v[i].jump, v[i].jt, v[i].br, v[i].bt);
         #1 chk_out($sformatf("row%0d", i), v[i].pc, v[i].fv, v[i].fif, v[i].fie, v[i].mis);
      end

`ifdef PC_PERF_CNT_EN
      chk("branch_cnt", branch_cnt_o, 32'd3);
      chk("jump_cnt", jump_cnt_o, 32'd4);
      chk("stall_cnt", stall_cnt_o, 32'd5);
`else
      chk("branch_cnt tied", branch_cnt_o, 32'h0);
      chk("jump_cnt tied", jump_cnt_o, 32'h0);
      chk("stall_cnt tied", stall_cnt_o, 32'h0);
`endif

      // Jump into REDIRECT, then pull reset in the middle of that cycle with a jump still pending.
      @(negedge clk);
      drive(0, 1, 1, 32'h0000_0300, 0, 32'h0);
      #1 chk_out("pre-redirect", 32'h0000_004C, 1, 1, 0, 0);
      @(negedge clk);
      drive(0, 1, 1, 32'h0000_0600, 0, 32'h0);
      #1 chk_out("redirect", 32'h0000_0300, 1, 1, 0, 0);
      #2 rst_n = 1'b0;
      #1 chk_out("async reset", 32'h0000_0100, 0, 0, 0, 0);
      chk("async reset jump_cnt", jump_cnt_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 1, 0, 32'h0, 0, 32'h0);
      #1 chk_out("reboot", 32'h0000_0100, 0, 0, 0, 0);
      @(negedge clk);
      #1 chk_out("reboot run0", 32'h0000_0100, 1, 0, 0, 0);
      @(negedge clk);
      #1 chk_out("reboot run1", 32'h0000_0104, 1, 0, 0, 0);
      @(negedge clk);
      #1 chk_out("reboot run2", 32'h0000_0108, 1, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
